// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: a chain of BPC full adders is reused
// over WIDTH/BPC cycles, LSB first, between valid/ready operand and result channels.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 16,
    parameter int BPC   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o,
    output logic             ovf_o,
    output logic             busy_o
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_cfg
            $error("serial_adder_ctrl: BPC must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, sreg, sreg_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             co_r, ovf_r;
    logic [BPC:0]     c;
    logic [BPC-1:0]   sum;
    logic             last;

    assign c[0] = carry;

    generate
        for (genvar i = 0; i < BPC; i++) begin : g_fa
            full_adder u_fa (
                .a  (opa[i]),
                .b  (opb[i]),
                .ci (c[i]),
                .s  (sum[i]),
                .co (c[i+1])
            );
        end
        // Sum bits enter from the MSB side so the result lands in place after N steps.
        if (BPC == WIDTH) begin : g_shift_full
            assign sreg_nxt = sum;
        end else begin : g_shift_part
            assign sreg_nxt = {sum, sreg[WIDTH-1:BPC]};
        end
    endgenerate

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_nxt = RUN;
            end
            RUN: begin
                busy_o = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opa   <= '0;
            opb   <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            co_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    // Subtract as A + ~B + ~borrow.
                    opa   <= a_i;
                    opb   <= sub_i ? ~b_i : b_i;
                    carry <= ci_i ^ sub_i;
                    sreg  <= '0;
                    cnt   <= '0;
                end
                RUN: begin
                    sreg  <= sreg_nxt;
                    opa   <= opa >> BPC;
                    opb   <= opb >> BPC;
                    carry <= c[BPC];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        co_r  <= c[BPC];
                        ovf_r <= c[BPC] ^ c[BPC-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_o   = sreg;
    assign co_o  = co_r;
    assign ovf_o = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: five DUT configurations share one clock/reset; ops are
// modelled at drive time and checked when the result handshake appears.

module tb_serial_adder_ctrl;
    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a [NI];
    logic [15:0] b [NI];
    logic        iv [NI], ci [NI], sub [NI], ordy [NI];
    wire  [15:0] s_w [NI];
    wire         ir [NI], ov [NI], co [NI], ovf [NI], busy [NI];

    function automatic int cfg_w(int k);
        return (k < 2) ? 8 : 16;
    endfunction
    function automatic int cfg_b(int k);
        case (k)
            0: return 1;
            1: return 2;
            2: return 1;
            3: return 4;
            default: return 16;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int W = (g < 2) ? 8 : 16;
            localparam int B = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 1 : (g == 3) ? 4 : 16;
            logic [W-1:0] s_l;
            serial_adder_ctrl #(.WIDTH(W), .BPC(B)) u_dut (
                .clk_i       (clk),
                .rst_i       (rst),
                .in_valid_i  (iv[g]),
                .in_ready_o  (ir[g]),
                .a_i         (a[g][W-1:0]),
                .b_i         (b[g][W-1:0]),
                .ci_i        (ci[g]),
                .sub_i       (sub[g]),
                .out_valid_o (ov[g]),
                .out_ready_i (ordy[g]),
                .s_o         (s_l),
                .co_o        (co[g]),
                .ovf_o       (ovf[g]),
                .busy_o      (busy[g])
            );
            assign s_w[g] = 16'(s_l);
        end
    endgenerate

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain integer add at width w; carry into MSB from the low w-1 bits.
    function automatic exp_t model(int k, logic [15:0] av, logic [15:0] bv, logic civ, logic subv);
        exp_t        e;
        int          w = cfg_w(k);
        int unsigned mask = (32'd1 << w) - 1;
        int unsigned lmask = (32'd1 << (w - 1)) - 1;
        int unsigned bb = subv ? (~32'(bv)) & mask : 32'(bv) & mask;
        int unsigned cc = (subv ? ~civ : civ) ? 1 : 0;
        int unsigned full = (32'(av) & mask) + bb + cc;
        int unsigned low = (32'(av) & lmask) + (bb & lmask) + cc;
        e.s   = 16'(full & mask);
        e.co  = full[w];
        e.ovf = low[w-1] ^ full[w];
        e.lat = w / cfg_b(k);
        return e;
    endfunction

    task automatic do_op(int k, logic [15:0] av, logic [15:0] bv, logic civ, logic subv, int stall);
        exp_t e;
        int   lat = 0;
        logic [15:0] held;
        chk("in_ready_idle", 32'(ir[k]), 1);
        iv[k] = 1'b1; a[k] = av; b[k] = bv; ci[k] = civ; sub[k] = subv;
        sbq.push_back(model(k, av, bv, civ, subv));
        @(posedge clk);
        @(negedge clk);
        iv[k] = 1'b0;
        while (!ov[k] && lat < 200) begin
            // Inputs and out_ready are ignored outside IDLE / DONE.
            iv[k] = 1'($urandom); a[k] = 16'($urandom); b[k] = 16'($urandom);
            ci[k] = 1'($urandom); sub[k] = 1'($urandom); ordy[k] = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b0;
        e = sbq.pop_front();
        if (lat >= 200) chk("timeout", 0, 1);
        chk("latency", 32'(lat), 32'(e.lat));
        chk("s", 32'(s_w[k]), 32'(e.s));
        chk("co", 32'(co[k]), 32'(e.co));
        chk("ovf", 32'(ovf[k]), 32'(e.ovf));
        chk("in_ready_done", 32'(ir[k]), 0);
        chk("busy_done", 32'(busy[k]), 1);
        held = s_w[k];
        for (int j = 0; j < stall; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 32'(ov[k]), 1);
            chk("stall_s", 32'(s_w[k]), 32'(held));
            chk("stall_in_ready", 32'(ir[k]), 0);
        end
        ordy[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[k] = 1'b0;
        chk("release_valid", 32'(ov[k]), 0);
        chk("release_in_ready", 32'(ir[k]), 1);
        chk("release_busy", 32'(busy[k]), 0);
        chk("idle_hold_s", 32'(s_w[k]), 32'(e.s));
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            iv[k] = 1'b0; a[k] = '0; b[k] = '0; ci[k] = 1'b0; sub[k] = 1'b0; ordy[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_in_ready", 32'(ir[k]), 1);
            chk("rst_valid", 32'(ov[k]), 0);
            chk("rst_busy", 32'(busy[k]), 0);
            chk("rst_s", 32'(s_w[k]), 0);
            chk("rst_co_ovf", {30'd0, co[k], ovf[k]}, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 16'h3C, 16'h15, 1'b1, 1'b0, 0);
        do_op(1, 16'hFF, 16'h01, 1'b0, 1'b0, 0);
        do_op(1, 16'h7F, 16'h01, 1'b0, 1'b0, 1);
        do_op(0, 16'h05, 16'h07, 1'b0, 1'b1, 0);
        do_op(0, 16'h80, 16'h01, 1'b0, 1'b1, 0);
        do_op(0, 16'hA5, 16'h5A, 1'b1, 1'b0, 5);

        // Reset during RUN: accept, three steps, then assert asynchronously.
        iv[0] = 1'b1; a[0] = 16'hFF; b[0] = 16'h00; ci[0] = 1'b0; sub[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrun_busy", 32'(busy[0]), 1);
        chk("midrun_s", 32'(s_w[0]), 32'h00E0);
        rst = 1'b1;
        #1;
        chk("async_rst_in_ready", 32'(ir[0]), 1);
        chk("async_rst_valid", 32'(ov[0]), 0);
        chk("async_rst_busy", 32'(busy[0]), 0);
        chk("async_rst_s", 32'(s_w[0]), 0);
        chk("async_rst_co_ovf", {30'd0, co[0], ovf[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(0, 16'h01, 16'h01, 1'b0, 1'b0, 0);

        for (int k = 2; k < NI; k++)
            for (int i = 0; i < 40; i++)
                do_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)));
        do_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(4, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        do_op(3, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
